// File: rtl/pattern_step_sequencer.sv
// rtl/pattern_step_sequencer.sv - parallel-in, serial-out rhythm pattern player with boundary-applied loads
module pattern_step_sequencer #(
  parameter int STEPS    = 8,
  parameter int TICK_DIV = 524288
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_run,
  input  logic                     i_load_valid,
  output logic                     o_load_ready,
  input  logic [STEPS-1:0]         i_load_pattern,
  output logic                     o_gate,
  output logic                     o_step_strobe,
  output logic [$clog2(STEPS)-1:0] o_step_index,
  output logic [STEPS-1:0]         o_pattern_out
);

  localparam int SW = $clog2(STEPS);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_presc;
  logic [SW-1:0]    r_step;
  logic [STEPS-1:0] r_pattern;
  logic [STEPS-1:0] r_hold;
  logic             r_hold_full;
  logic             r_strobe;

  state_t           w_state_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic [SW-1:0]    w_step_nxt;
  logic [STEPS-1:0] w_pattern_nxt;
  logic [STEPS-1:0] w_hold_nxt;
  logic             w_hold_full_nxt;
  logic             w_strobe_nxt;
  logic             w_xfer;
  logic             w_tick;
  logic             w_wrap;

  assign w_xfer = i_load_valid & ~r_hold_full;
  assign w_tick = (r_presc == TICK_LAST);
  assign w_wrap = w_tick & (r_step == STEP_LAST);

  // Next-state, prescaler, step and pattern/hold bookkeeping
  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = r_presc;
    w_step_nxt      = r_step;
    w_pattern_nxt   = r_pattern;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_strobe_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_presc_nxt = '0;
        w_step_nxt  = '0;
        // A pattern left in hold by a stop is applied now; loads go straight to active
        if (r_hold_full) begin
          w_pattern_nxt   = r_hold;
          w_hold_full_nxt = 1'b0;
        end
        if (w_xfer) begin
          w_pattern_nxt = i_load_pattern;
        end
        if (i_run) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_run) begin
          w_state_nxt = ST_IDLE;
          w_presc_nxt = '0;
          w_step_nxt  = '0;
        end else begin
          w_strobe_nxt = w_tick;
          if (w_tick) begin
            w_presc_nxt = '0;
            w_step_nxt  = (r_step == STEP_LAST) ? '0 : r_step + SW'(1);
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
          // Apply only at the bar boundary so a bar never mixes old and new
          if (w_wrap && r_hold_full) begin
            w_pattern_nxt   = r_hold;
            w_hold_full_nxt = 1'b0;
          end
        end
        // Hold is empty whenever a transfer happens, so this never collides with the apply above
        if (w_xfer) begin
          w_hold_nxt      = i_load_pattern;
          w_hold_full_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_step      <= '0;
      r_pattern   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_step      <= w_step_nxt;
      r_pattern   <= w_pattern_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_strobe    <= w_strobe_nxt;
    end
  end

  // Gate is combinational so it follows pattern[0] in the first RUN cycle
  always_comb begin
    o_gate = (r_state == ST_RUN) & r_pattern[r_step];
  end

  assign o_load_ready  = ~r_hold_full;
  assign o_step_strobe = r_strobe;
  assign o_step_index  = r_step;
  assign o_pattern_out = r_pattern;

endmodule

// File: tb/tb_pattern_step_sequencer.sv
// tb/tb_pattern_step_sequencer.sv - self-checking bench for pattern_step_sequencer
module tb_pattern_step_sequencer;

  localparam int STEPS = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       lv;
  logic [7:0] lp;

  logic       ready_a, gate_a, strobe_a;
  logic [2:0] step_a;
  logic [7:0] pat_a;
  logic       ready_b, gate_b, strobe_b;
  logic [2:0] step_b;
  logic [7:0] pat_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_step_sequencer #(.STEPS(8), .TICK_DIV(4)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_load_valid(lv),
    .o_load_ready(ready_a), .i_load_pattern(lp), .o_gate(gate_a),
    .o_step_strobe(strobe_a), .o_step_index(step_a), .o_pattern_out(pat_a)
  );

  pattern_step_sequencer #(.STEPS(8), .TICK_DIV(1)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_load_valid(lv),
    .o_load_ready(ready_b), .i_load_pattern(lp), .o_gate(gate_b),
    .o_step_strobe(strobe_b), .o_step_index(step_b), .o_pattern_out(pat_b)
  );

  // Reference model: playback time counted in cycles since play started
  bit         m_running[2];
  int         m_cyc[2];
  logic [7:0] m_pat[2];
  logic [7:0] m_hold[2];
  bit         m_hfull[2];
  int         m_div[2] = '{4, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_running[i] = 0;
        m_cyc[i]     = 0;
        m_pat[i]     = '0;
        m_hfull[i]   = 0;
      end else begin
        bit xfer;
        xfer = lv && !m_hfull[i];
        if (!m_running[i]) begin
          if (m_hfull[i]) begin
            m_pat[i]   = m_hold[i];
            m_hfull[i] = 0;
          end
          if (xfer) m_pat[i] = lp;
          if (run) begin
            m_running[i] = 1;
            m_cyc[i]     = 0;
          end
        end else if (!run) begin
          m_running[i] = 0;
          m_cyc[i]     = 0;
          if (xfer) begin
            m_hold[i]  = lp;
            m_hfull[i] = 1;
          end
        end else begin
          if (((m_cyc[i] + 1) % (m_div[i] * STEPS)) == 0 && m_hfull[i]) begin
            m_pat[i]   = m_hold[i];
            m_hfull[i] = 0;
          end
          if (xfer) begin
            m_hold[i]  = lp;
            m_hfull[i] = 1;
          end
          m_cyc[i]++;
        end
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      int         es;
      logic [7:0] ep;
      logic       eg, est;
      ep  = m_pat[i];
      es  = m_running[i] ? (m_cyc[i] / m_div[i]) % STEPS : 0;
      eg  = m_running[i] && ep[es];
      est = m_running[i] && m_cyc[i] > 0 && (m_cyc[i] % m_div[i]) == 0;
      check($sformatf("gate%0d", i),   i == 0 ? gate_a   : gate_b,   eg);
      check($sformatf("step%0d", i),   i == 0 ? step_a   : step_b,   es);
      check($sformatf("strobe%0d", i), i == 0 ? strobe_a : strobe_b, est);
      check($sformatf("ready%0d", i),  i == 0 ? ready_a  : ready_b,  !m_hfull[i]);
      check($sformatf("pattern%0d", i), i == 0 ? pat_a   : pat_b,    ep);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    int gseq[8] = '{1, 0, 1, 0, 0, 0, 0, 1};
    int guard;

    reset = 1'b1; run = 1'b0; lv = 1'b0; lp = '0;
    cycle();
    cycle();
    check("rst_gate", gate_a, 0);
    check("rst_step", step_a, 0);
    check("rst_pattern", pat_a, 0);
    check("rst_ready", ready_a, 1);
    check("rst_strobe", strobe_a, 0);
    reset = 1'b0;

    // IDLE load then play
    lv = 1'b1; lp = 8'h85;
    cycle();
    lv = 1'b0;
    check("idle_load", pat_a, 8'h85);
    check("idle_load_ready", ready_a, 1);
    run = 1'b1;
    cycle();
    for (int s = 0; s < 8; s++) begin
      check($sformatf("gseq_s%0d", s), gate_a, gseq[s]);
      check($sformatf("strobe_s%0d", s), strobe_a, s != 0);
      for (int c = 0; c < 4; c++) cycle();
    end
    check("bar2_step0", step_a, 0);

    // Deferred load at step 3
    for (int c = 0; c < 12; c++) cycle();
    check("at_step3", step_a, 3);
    lv = 1'b1; lp = 8'hFF;
    cycle();
    lv = 1'b0;
    check("defer_ready", ready_a, 0);
    check("defer_keep", pat_a, 8'h85);
    for (int c = 0; c < 18; c++) cycle();
    check("pre_wrap_step", step_a, 7);
    check("pre_wrap_pattern", pat_a, 8'h85);
    cycle();
    check("wrap_pattern", pat_a, 8'hFF);
    check("wrap_ready", ready_a, 1);

    // Back-pressure: fill hold, then offer 0x0F until accepted
    lv = 1'b1; lp = 8'h3C;
    cycle();
    check("bp_full", ready_a, 0);
    lp = 8'h0F;
    cycle();
    cycle();
    check("bp_ignored", pat_a, 8'hFF);
    guard = 0;
    while (ready_a !== 1'b1 && guard < 64) begin
      cycle();
      guard++;
    end
    check("bp_wait_bound", guard < 64, 1);
    check("bp_applied", pat_a, 8'h3C);
    cycle();
    lv = 1'b0;
    check("bp_0f_taken", ready_a, 0);

    // Stop mid step 5, then restart
    guard = 0;
    while (((m_cyc[0] / 4) % 8) != 5 && guard < 64) begin
      cycle();
      guard++;
    end
    cycle();
    run = 1'b0;
    cycle();
    check("stop_gate", gate_a, 0);
    check("stop_step", step_a, 0);
    cycle();
    check("stop_apply", pat_a, 8'h0F);
    check("stop_ready", ready_a, 1);
    run = 1'b1;
    cycle();
    check("restart_gate", gate_a, 1);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("restart_step0", step_a, 0);
    end
    cycle();
    check("restart_step1", step_a, 1);

    // Load accepted on the exact wrap edge
    guard = 0;
    while (((m_cyc[0] + 1) % 32) != 0 && guard < 64) begin
      cycle();
      guard++;
    end
    check("coll_pre_step", step_a, 7);
    lv = 1'b1; lp = 8'hA5;
    cycle();
    lv = 1'b0;
    check("coll_not_now", pat_a, 8'h0F);
    check("coll_held", ready_a, 0);
    for (int c = 0; c < 31; c++) cycle();
    check("coll_still_old", pat_a, 8'h0F);
    cycle();
    check("coll_applied", pat_a, 8'hA5);
    check("coll_ready", ready_a, 1);

    // TICK_DIV=1 instance advances every cycle with strobe held high
    for (int c = 0; c < 10; c++) begin
      int prev;
      prev = m_cyc[1] % 8;
      cycle();
      check("div1_strobe", strobe_b, 1);
      check("div1_step", step_b, (prev + 1) % 8);
    end

    // Randomized stimulus against the model
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      run   = ($urandom_range(0, 24) != 0);
      lv    = ($urandom_range(0, 3) == 0);
      lp    = 8'($urandom);
      cycle();
    end
    reset = 1'b0; run = 1'b0; lv = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
